oflow_div_seq: RTL and testbench
================================

Name: oflow_div_seq

Overview:
Multi-cycle sequential integer divider with a start/complete handshake. It computes quotient = a / b and remainder = a % b over a fixed number of clock cycles. It is used by the IoU block (oflow_calc_iou) for the final division, configured as a 44-bit dividend (Intersection << 22) and a 22-bit divisor (union area). Quotient bits are produced by restoring division, several bits per cycle.

Parameters:
- a_width, 8, dividend and quotient width; legal range 2..64.
- b_width, 8, divisor and remainder width; legal range 2..a_width.
- num_cyc, 3, total latency in cycles from the start sample to complete; legal range 3..a_width. Bits per cycle R = ceil(a_width/num_cyc).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  freeze: while high, internal state, counter and outputs do not change
- start  input  1  one-cycle pulse; operands are captured on this edge
- a  input  a_width  dividend
- b  input  b_width  divisor
- complete  output  1  high = idle with results valid; low = busy
- divide_by_0  output  1  b was zero for the last completed operation
- quotient  output  a_width  result
- remainder  output  b_width  result

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: complete=1, divide_by_0=0, quotient=0, remainder=0. The internal counter and operand registers are cleared.
- Input mode is registered. When start=1 and hold=0 at edge T0:
  - latch a and b;
  - clear the partial remainder;
  - load the counter with num_cyc-1;
  - drive complete=0 from T0 onward.
- Busy cycle: each edge with hold=0 performs R restoring steps, MSB-first. A step is one shift-in of the next dividend bit, a trial subtract of b, and a conditional restore. The counter then decrements.
- The final cycle handles the leftover bits when a_width is not a multiple of R. Unused step slots pass the value through unchanged.
- At edge T0+num_cyc:
  - quotient, remainder and divide_by_0 are registered;
  - complete=1.
  - Outputs hold their values until the next accepted start.
- Latency: results are valid, and complete is high, exactly num_cyc cycles after the start edge, not counting held cycles.
- Divide by zero: divide_by_0=1, quotient = all ones, remainder = a[b_width-1:0]. Latency is unchanged.
- start while busy: abort the current operation and restart with the new operands. The old results are never presented.
- start together with hold=1: ignored.
- hold during busy: the counter and datapath freeze, and complete stays 0.
- hold while idle: no effect.
- Reset mid-operation: return immediately to the reset values. The operation is lost.
- The partial remainder register is b_width+1 bits wide. The final remainder is the low b_width bits, which is always less than b.
- States: IDLE (complete=1) and BUSY (counter > 0 or on the final step). IDLE goes to BUSY on start. BUSY goes to IDLE after the final step. BUSY goes to BUSY with reload on start.

Optional Feature:
- Macro: OFLOW_DIV_SEQ_TC_MODE_EN.
- Defined: operands are two's complement.
  - Inputs are converted to magnitudes at capture.
  - Quotient is negated when the operand signs differ, so it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Divide by zero gives quotient = most-positive value if a >= 0, most-negative value otherwise; remainder = a[b_width-1:0].
- Undefined: unsigned only; there is no sign logic.

Decomposition:
- Shared package oflow_div_pkg contains:
  - the state enum (IDLE, BUSY);
  - the function computing R from a_width and num_cyc;
  - counter width = $clog2(num_cyc+1).
- One sub-module, oflow_div_seq_step: a combinational single radix-2 restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated R times in a generate chain.

Test Plan:
- a_width=8, b_width=8, num_cyc=3; a=200, b=7, start pulse -> complete low for 3 cycles, then quotient=28, remainder=4, divide_by_0=0.
- Same configuration; a=13, b=0 -> after 3 cycles divide_by_0=1, quotient=8'hFF, remainder=13.
- a=100, b=9, start, then hold=1 for 4 cycles mid-operation -> complete stays low 4 extra cycles; result quotient=11, remainder=1.
- Start a=50, b=5; re-start one cycle later with a=255, b=16 -> a single completion, 3 cycles after the second start: quotient=15, remainder=15. The result 10 never appears.
- a_width=44, b_width=22, num_cyc=3; a=1000<<22, b=4000 -> quotient=1048576, remainder=0. Also: rst_n low mid-operation -> complete=1, quotient=0 asynchronously.
- OFLOW_DIV_SEQ_TC_MODE_EN defined, 8-bit; a=-7 (8'hF9), b=2 -> quotient=8'hFD (-3), remainder=8'hFF (-1).

Source files
------------

// File: rtl/oflow_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_div_pkg
//  Description : Shared types and sizing helpers for the sequential divider
//                (state encoding, bits-per-cycle and counter-width helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package oflow_div_pkg;

    // Two-state controller encoding: IDLE (results valid) / BUSY (dividing)
    typedef logic [0:0] div_state_t;
    localparam div_state_t c_ST_IDLE = 1'b0;
    localparam div_state_t c_ST_BUSY = 1'b1;

    // Restoring steps performed per busy cycle: ceil(a_w / n_cyc)
    function automatic int calc_bits_per_cyc(input int a_w, input int n_cyc);
        return (a_w + n_cyc - 1) / n_cyc;
    endfunction

    // Width of the cycle counter, which is loaded with n_cyc-1
    function automatic int calc_cnt_width(input int n_cyc);
        return $clog2(n_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oflow_div_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_div_seq_step
//  Description : One combinational radix-2 restoring division step: shift in
//                the next dividend bit, trial-subtract the divisor, restore
//                when the trial goes negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_div_seq_step #(
    parameter int b_width = 8
) (
    input  logic [b_width:0]   rem_in,
    input  logic               dvd_bit,
    input  logic [b_width-1:0] divisor,
    output logic [b_width:0]   rem_out,
    output logic               q_bit
);

    logic [b_width:0] w_shift;
    logic [b_width:0] w_dvs;
    logic [b_width:0] w_diff;

    // With a non-zero divisor rem_in < divisor, so its top bit is clear and
    // the shifted value fits b_width+1 bits. A set top bit (only reachable
    // with a zero divisor) means the true shifted value exceeds the divisor.
    assign w_shift = {rem_in[b_width-1:0], dvd_bit};
    assign w_dvs   = {1'b0, divisor};
    assign w_diff  = w_shift - w_dvs;
    assign q_bit   = rem_in[b_width] | (w_shift >= w_dvs);
    assign rem_out = q_bit ? w_diff : w_shift;

endmodule
`default_nettype wire

// File: rtl/oflow_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : oflow_div_seq
//  Description : Multi-cycle restoring integer divider with start/complete
//                handshake. R = ceil(a_width/num_cyc) quotient bits are
//                produced per cycle; results appear num_cyc unheld cycles
//                after the start edge. A start while busy restarts.
//                Optional macro OFLOW_DIV_SEQ_TC_MODE_EN selects two's
//                complement operands (truncating division, remainder takes
//                the dividend sign).
//  Revision    : 1.0 - initial release
// ============================================================================
module oflow_div_seq
    import oflow_div_pkg::*;
#(
    parameter int a_width = 8,
    parameter int b_width = 8,
    parameter int num_cyc = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               start,
    input  logic [a_width-1:0] a,
    input  logic [b_width-1:0] b,
    output logic               complete,
    output logic               divide_by_0,
    output logic [a_width-1:0] quotient,
    output logic [b_width-1:0] remainder
);

    localparam int c_R  = calc_bits_per_cyc(a_width, num_cyc);
    // The dividend is zero-padded at the MSB end up to num_cyc*R bits. Pad
    // slots see zero bits with a zero partial remainder, so they yield a zero
    // quotient bit and leave the partial remainder unchanged.
    localparam int c_W  = c_R * num_cyc;
    localparam int c_CW = calc_cnt_width(num_cyc);

    div_state_t         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [c_W-1:0]     r_work;     // dividend bits shift out MSB-first, quotient bits shift in
    logic [b_width:0]   r_prem;     // partial remainder
    logic [b_width-1:0] r_b;        // divisor magnitude
    logic [b_width-1:0] r_a_lo;     // raw low dividend bits for the divide-by-zero remainder
    logic               r_div0;
    logic [a_width-1:0] r_quot;
    logic [b_width-1:0] r_rem;

    logic [a_width-1:0] w_a_mag;
    logic [b_width-1:0] w_b_mag;
    logic [c_W-1:0]     w_work_init;
    logic [b_width:0]   w_prem [0:c_R];
    logic [c_R-1:0]     w_qbits;
    logic [c_W-1:0]     w_work_next;
    logic [a_width-1:0] w_q_mag;
    logic [b_width-1:0] w_r_mag;
    logic [a_width-1:0] w_q_res;
    logic [b_width-1:0] w_r_res;
    logic               w_div0;
    logic               w_accept;
    logic               w_advance;
    logic               w_last;

`ifdef OFLOW_DIV_SEQ_TC_MODE_EN
    logic r_a_neg;
    logic r_b_neg;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = a[a_width-1];
    assign w_b_neg = b[b_width-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
`endif

    assign w_accept  = start & ~hold;
    assign w_advance = ~hold & ~start & (r_state == c_ST_BUSY);
    assign w_last    = w_advance & (r_cnt == '0);
    assign w_div0    = (r_b == '0);

    // Zero-extend the dividend magnitude into the working register
    always_comb begin
        w_work_init                = '0;
        w_work_init[a_width-1:0]   = w_a_mag;
    end

    // Chain of R restoring steps evaluated each busy cycle
    assign w_prem[0] = r_prem;
    for (genvar j = 0; j < c_R; j++) begin : g_step
        oflow_div_seq_step #(
            .b_width (b_width)
        ) u_step (
            .rem_in  (w_prem[j]),
            .dvd_bit (r_work[c_W-1-j]),
            .divisor (r_b),
            .rem_out (w_prem[j+1]),
            .q_bit   (w_qbits[c_R-1-j])
        );
    end

    assign w_work_next = {r_work[c_W-c_R-1:0], w_qbits};
    assign w_q_mag     = w_work_next[a_width-1:0];
    assign w_r_mag     = w_prem[c_R][b_width-1:0];

    // Final result selection, including divide-by-zero and sign fix-up
    always_comb begin
        w_q_res = w_q_mag;
        w_r_res = w_r_mag;
`ifdef OFLOW_DIV_SEQ_TC_MODE_EN
        if (w_div0) begin
            w_q_res = r_a_neg ? {1'b1, {(a_width-1){1'b0}}} : {1'b0, {(a_width-1){1'b1}}};
            w_r_res = r_a_lo;
        end else begin
            w_q_res = (r_a_neg ^ r_b_neg) ? -w_q_mag : w_q_mag;
            w_r_res = r_a_neg ? -w_r_mag : w_r_mag;
        end
`else
        if (w_div0) begin
            w_q_res = '1;
            w_r_res = r_a_lo;
        end
`endif
    end

    // Controller: IDLE->BUSY on start, count down busy cycles, BUSY->IDLE on last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= c_ST_BUSY;
            r_cnt   <= c_CW'(num_cyc - 1);
        end else if (w_last) begin
            r_state <= c_ST_IDLE;
        end else if (w_advance) begin
            r_cnt   <= r_cnt - c_CW'(1);
        end
    end

    // Datapath: capture operands on start, run R steps per unheld busy cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_prem  <= '0;
            r_b     <= '0;
            r_a_lo  <= '0;
`ifdef OFLOW_DIV_SEQ_TC_MODE_EN
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
`endif
        end else if (w_accept) begin
            r_work  <= w_work_init;
            r_prem  <= '0;
            r_b     <= w_b_mag;
            r_a_lo  <= a[b_width-1:0];
`ifdef OFLOW_DIV_SEQ_TC_MODE_EN
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
`endif
        end else if (w_advance) begin
            r_work  <= w_work_next;
            r_prem  <= w_prem[c_R];
        end
    end

    // Result registers: updated only when an operation finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (w_last) begin
            r_div0 <= w_div0;
            r_quot <= w_q_res;
            r_rem  <= w_r_res;
        end
    end

    assign complete    = (r_state == c_ST_IDLE);
    assign divide_by_0 = r_div0;
    assign quotient    = r_quot;
    assign remainder   = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_oflow_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oflow_div_seq
//  Description : Self-checking bench for oflow_div_seq. Three instances
//                (8/8/3, 44/22/3, 10/5/4) are driven with directed and
//                random operations and compared with an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oflow_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        hold;
    logic        st0, st1, st2;
    logic [7:0]  a0, b0;
    logic [43:0] a1;
    logic [21:0] b1;
    logic [9:0]  a2;
    logic [4:0]  b2;
    logic        c0, c1, c2, z0, z1, z2;
    logic [7:0]  q0, r0;
    logic [43:0] q1;
    logic [21:0] r1;
    logic [9:0]  q2;
    logic [4:0]  r2;

    int n_vec = 0;
    int n_err = 0;
    int aw_t [3];
    int bw_t [3];
    int nc_t [3];
    logic [63:0] last_q [3];
    logic [63:0] last_r [3];
    logic        last_z [3];

    oflow_div_seq #(.a_width(8), .b_width(8), .num_cyc(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(st0), .a(a0), .b(b0),
        .complete(c0), .divide_by_0(z0), .quotient(q0), .remainder(r0));

    oflow_div_seq #(.a_width(44), .b_width(22), .num_cyc(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(st1), .a(a1), .b(b1),
        .complete(c1), .divide_by_0(z1), .quotient(q1), .remainder(r1));

    oflow_div_seq #(.a_width(10), .b_width(5), .num_cyc(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(st2), .a(a2), .b(b2),
        .complete(c2), .divide_by_0(z2), .quotient(q2), .remainder(r2));

    // Reference: plain integer division on the masked operands
    task automatic ref_div(input int aw, input int bw, input logic [63:0] a_in, input logic [63:0] b_in,
                           output logic [63:0] q, output logic [63:0] r, output logic dz);
        logic [63:0] am, bm, av, bv;
        am = (64'd1 << aw) - 64'd1;
        bm = (64'd1 << bw) - 64'd1;
        av = a_in & am;
        bv = b_in & bm;
        dz = (bv == 64'd0);
`ifdef OFLOW_DIV_SEQ_TC_MODE_EN
        begin
            longint sa, sb;
            sa = longint'(av[aw-1] ? (av | ~am) : av);
            sb = longint'(bv[bw-1] ? (bv | ~bm) : bv);
            if (dz) begin
                q = (sa < 0) ? (64'd1 << (aw-1)) : ((64'd1 << (aw-1)) - 64'd1);
                r = av & bm;
            end else begin
                q = 64'(sa / sb) & am;
                r = 64'(sa % sb) & bm;
            end
        end
`else
        if (dz) begin
            q = am;
            r = av & bm;
        end else begin
            q = av / bv;
            r = av % bv;
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input int w, output logic cmp, output logic [63:0] q,
                           output logic [63:0] r, output logic dz);
        case (w)
            0:       begin cmp = c0; q = 64'(q0); r = 64'(r0); dz = z0; end
            1:       begin cmp = c1; q = 64'(q1); r = 64'(r1); dz = z1; end
            default: begin cmp = c2; q = 64'(q2); r = 64'(r2); dz = z2; end
        endcase
    endtask

    task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b);
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        case (w)
            0:       begin a0 = a[7:0];  b0 = b[7:0];  st0 = 1'b1; end
            1:       begin a1 = a[43:0]; b1 = b[21:0]; st1 = 1'b1; end
            default: begin a2 = a[9:0];  b2 = b[4:0];  st2 = 1'b1; end
        endcase
    endtask

    task automatic check_outputs(input string tag, input int w, input logic exp_c,
                                 input logic [63:0] eq, input logic [63:0] er, input logic ez);
        logic cmp, dz;
        logic [63:0] q, r;
        get_out(w, cmp, q, r, dz);
        check({tag, ":complete"}, 64'(cmp), 64'(exp_c));
        check({tag, ":quotient"}, q, eq);
        check({tag, ":remainder"}, r, er);
        check({tag, ":div0"}, 64'(dz), 64'(ez));
    endtask

    // Start one operation, optionally hold mid-flight, then check latency and result
    task automatic run_op(input string tag, input int w, input logic [63:0] a, input logic [63:0] b,
                          input int hold_at, input int hold_len);
        logic cmp, dz;
        logic [63:0] q, r, eq, er;
        logic ez;
        drive(w, a, b);
        tick();
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        for (int e = 0; e < nc_t[w]; e++) begin
            get_out(w, cmp, q, r, dz);
            check({tag, ":busy"}, 64'(cmp), 64'd0);
            if (e == hold_at) begin
                hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    tick();
                    get_out(w, cmp, q, r, dz);
                    check({tag, ":held"}, 64'(cmp), 64'd0);
                end
                hold = 1'b0;
            end
            tick();
        end
        ref_div(aw_t[w], bw_t[w], a, b, eq, er, ez);
        check_outputs({tag, ":done"}, w, 1'b1, eq, er, ez);
        last_q[w] = eq;
        last_r[w] = er;
        last_z[w] = ez;
    endtask

    initial begin
        logic [63:0] ra, rb;
        int w, hat, hlen;

        aw_t = '{8, 44, 10};
        bw_t = '{8, 22, 5};
        nc_t = '{3, 3, 4};
        rst_n = 1'b0; hold = 1'b0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) check_outputs("reset", i, 1'b1, 64'd0, 64'd0, 1'b0);
        #2 rst_n = 1'b1;
        tick();

        // Directed operations
        run_op("div_200_7", 0, 64'd200, 64'd7, -1, 0);
        run_op("div_by_zero", 0, 64'd13, 64'd0, -1, 0);
        run_op("hold_mid", 0, 64'd100, 64'd9, 1, 4);

        // Restart while busy: only the second operation may complete
        drive(0, 64'd50, 64'd5);
        tick();
        st0 = 1'b0;
        check("restart:busy_first", 64'(c0), 64'd0);
        run_op("restart", 0, 64'd255, 64'd16, -1, 0);

        // Start with hold high is ignored
        hold = 1'b1;
        drive(0, 64'd77, 64'd3);
        tick();
        st0 = 1'b0;
        hold = 1'b0;
        tick();
        check_outputs("start_held", 0, 1'b1, last_q[0], last_r[0], last_z[0]);

        run_op("tc_neg7_2", 0, 64'hF9, 64'd2, -1, 0);
        run_op("wide_iou", 1, 64'd1000 << 22, 64'd4000, -1, 0);
        run_op("pad_cfg", 2, 64'd1023, 64'd3, 2, 2);

        // Asynchronous reset in the middle of an operation
        drive(1, 64'd123456789, 64'd77);
        tick();
        st1 = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1, 1'b1, 64'd0, 64'd0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check("async_rst:idle", 64'(c1), 64'd1);

        // Random operations with random holds, restarts and zero divisors
        for (int i = 0; i < 40; i++) begin
            w    = int'($urandom_range(0, 2));
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(1, 7));
            if ($urandom_range(0, 5) == 0) rb = 64'd0;
            hat  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nc_t[w] - 1));
            hlen = int'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) begin
                drive(w, {$urandom, $urandom}, {$urandom, $urandom});
                tick();
            end
            run_op("random", w, ra, rb, hat, hlen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
